// File: rtl/z80_bus_arbiter.sv
// Z80 external bus arbiter: shares the CPU bus with NREQ DMA-style requesters,
// round-robin grant with bounded hold and a guaranteed CPU-owned gap between grants.
module z80_bus_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_HOLD = 16,
    parameter int CPU_GAP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cen,
    input  logic [NREQ-1:0] req,
    input  logic            busak_n,
    output logic            busrq_n,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      owner,
    output logic            dma_active,
    output logic            forced_release
);

    // state     | meaning
    // S_IDLE    | CPU owns bus, no request outstanding
    // S_REQ     | busrq_n asserted, waiting for busak_n
    // S_GRANT   | one requester owns the bus
    // S_RELEASE | one-cycle turnaround, grant dropped, busrq_n still low
    // S_GAP     | busrq_n released, CPU owns bus for at least CPU_GAP cycles
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_RELEASE,
        S_GAP
    } state_t;

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int GAP_W  = (CPU_GAP < 1) ? 1 : $clog2(CPU_GAP + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
    localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(CPU_GAP);

    state_t            r_state;
    logic              r_busrq_n;
    logic [NREQ-1:0]   r_grant;
    logic [2:0]        r_owner;
    logic              r_dma;
    logic              r_forced;
    logic [2:0]        r_rr;
    logic [HOLD_W-1:0] r_hold;
    logic [GAP_W-1:0]  r_gap;

    logic [2:0]        w_win;
    logic              w_found;
    logic [2:0]        w_next_rr;

    // First pass covers indices at/after the pointer, second pass wraps to the low ones.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (i >= int'(r_rr))) begin
                w_win   = 3'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i]) begin
                w_win   = 3'(i);
                w_found = 1'b1;
            end
        end
        w_next_rr = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busrq_n <= 1'b1;
            r_grant   <= '0;
            r_owner   <= '0;
            r_dma     <= 1'b0;
            r_forced  <= 1'b0;
            r_rr      <= '0;
            r_hold    <= '0;
            r_gap     <= '0;
        end else if (cen) begin
            r_forced <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state   <= S_REQ;
                        r_busrq_n <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!busak_n) begin
                        if (|req) begin
                            r_state <= S_GRANT;
                            r_grant <= NREQ'(1) << w_win;
                            r_owner <= w_win;
                            r_rr    <= w_next_rr;
                            r_hold  <= HOLD_W'(1);
                            r_dma   <= 1'b1;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end
                end
                S_GRANT: begin
                    // CPU dropping acknowledge overrides everything: bus is no longer ours.
                    if (busak_n) begin
                        r_state   <= S_GAP;
                        r_grant   <= '0;
                        r_dma     <= 1'b0;
                        r_busrq_n <= 1'b1;
                        r_gap     <= '0;
                    end else if ((req & r_grant) == '0) begin
                        r_state <= S_RELEASE;
                        r_grant <= '0;
                        r_dma   <= 1'b0;
                    end else if ((MAX_HOLD != 0) && (r_hold == HOLD_LIM)) begin
                        r_state  <= S_RELEASE;
                        r_grant  <= '0;
                        r_dma    <= 1'b0;
                        r_forced <= 1'b1;
                    end else if (r_hold != HOLD_SAT) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    r_state   <= S_GAP;
                    r_busrq_n <= 1'b1;
                    r_gap     <= '0;
                end
                S_GAP: begin
                    // Gap count starts once the CPU has actually taken the bus back.
                    if (busak_n || (r_gap != '0)) begin
                        if (r_gap >= GAP_LIM) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busrq_n <= 1'b1;
                    r_grant   <= '0;
                    r_dma     <= 1'b0;
                end
            endcase
        end
    end

    assign busrq_n        = r_busrq_n;
    assign grant          = r_grant;
    assign owner          = r_owner;
    assign dma_active     = r_dma;
    assign forced_release = r_forced;

endmodule
